// File: rtl/character_redraw_ctrl.sv
// Player character redraw controller.
// On a position request, erases the old 9x5 character rectangle with the
// background colour and then draws the new one. Pixels go out one per cycle
// to the VGA adapter's pixel-write port. DoneDrawing pulses once the update
// is complete.
module character_redraw_ctrl #(
  parameter int         CHAR_W     = 9,
  parameter int         CHAR_H     = 5,
  parameter int         BASE_Y     = 102,
  parameter logic [2:0] CHAR_COLOR = 3'b011,
  parameter logic [2:0] BG_COLOR   = 3'b000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] NewPos,
  input  logic       PosValid,
  output logic       Busy,
  output logic [7:0] XOut,
  output logic [6:0] YOut,
  output logic [2:0] Color,
  output logic       Plot,
  output logic       DoneDrawing,
  output logic       ErrPulse
);

  localparam int XCW = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
  localparam int YCW = (CHAR_H > 1) ? $clog2(CHAR_H) : 1;

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} stateT;

  stateT          state;
  stateT          stateNext;
  logic [1:0]     oldPos;
  logic           oldValid;
  logic [1:0]     targetPos;
  logic [XCW-1:0] xCounter;
  logic [YCW-1:0] yCounter;
  logic           plotReg;

  logic           accept;
  logic           codeValid;
  logic           lastPixel;
  logic           clearCounters;
  logic           advance;
  logic           latchTarget;
  logic [1:0]     scanPos;
  logic [7:0]     xBase;
  logic [2:0]     scanColor;

  // A request only counts once the previous update has fully finished,
  // including its DoneDrawing cycle; anything else is dropped.
  always_comb begin
    accept    = PosValid && (state == IDLE) && !DoneDrawing;
    codeValid = (NewPos[3:2] == 2'b00);
    lastPixel = (xCounter == XCW'(CHAR_W - 1)) && (yCounter == YCW'(CHAR_H - 1));
  end

  // Next-state logic and the control strobes for the counters and latches.
  always_comb begin
    stateNext     = state;
    clearCounters = 1'b0;
    advance       = 1'b0;
    latchTarget   = 1'b0;
    case (state)
      IDLE: begin
        if (accept && codeValid) begin
          latchTarget   = 1'b1;
          clearCounters = 1'b1;
          if (!oldValid)                  stateNext = DRAW;
          else if (NewPos[1:0] != oldPos) stateNext = ERASE;
          else                            stateNext = DONE;
        end
      end
      ERASE: begin
        advance = 1'b1;
        if (lastPixel) begin
          stateNext     = DRAW;
          clearCounters = 1'b1;
        end
      end
      DRAW: begin
        advance = 1'b1;
        if (lastPixel) begin
          stateNext     = DONE;
          clearCounters = 1'b1;
        end
      end
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Erase works on the old position in the background colour; draw works on
  // the target position in the character colour.
  always_comb begin
    scanPos   = (state == ERASE) ? oldPos : targetPos;
    scanColor = (state == ERASE) ? BG_COLOR : CHAR_COLOR;
    case (scanPos)
      2'd0:    xBase = 8'd6;
      2'd1:    xBase = 8'd24;
      2'd2:    xBase = 8'd78;
      default: xBase = 8'd132;
    endcase
  end

  // State register, row-major scan counters and position bookkeeping.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      xCounter  <= '0;
      yCounter  <= '0;
      oldPos    <= '0;
      oldValid  <= 1'b0;
      targetPos <= '0;
    end else begin
      state <= stateNext;
      if (latchTarget) targetPos <= NewPos[1:0];
      if (clearCounters) begin
        xCounter <= '0;
        yCounter <= '0;
      end else if (advance) begin
        if (xCounter == XCW'(CHAR_W - 1)) begin
          xCounter <= '0;
          yCounter <= yCounter + 1'b1;
        end else begin
          xCounter <= xCounter + 1'b1;
        end
      end
      if (state == DONE) begin
        oldPos   <= targetPos;
        oldValid <= 1'b1;
      end
    end
  end

  // Pixel stream and status pulses, registered one cycle behind the scan.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      plotReg     <= 1'b0;
      XOut        <= '0;
      YOut        <= '0;
      Color       <= '0;
      DoneDrawing <= 1'b0;
      ErrPulse    <= 1'b0;
    end else begin
      plotReg <= (state == ERASE) || (state == DRAW);
      if ((state == ERASE) || (state == DRAW)) begin
        XOut  <= xBase + 8'(xCounter);
        YOut  <= 7'(BASE_Y) + 7'(yCounter);
        Color <= scanColor;
      end
      DoneDrawing <= (state == DONE);
      ErrPulse    <= accept && !codeValid;
    end
  end

  // Busy covers the DoneDrawing cycle so the next request waits for it, and
  // Plot is masked so a pixel already in flight never writes during reset.
  always_comb begin
    Busy = (state != IDLE) || DoneDrawing;
    Plot = plotReg && !Reset;
  end

endmodule
